// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, main FSM state encoding and aluop codes shared by the controller
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;
endpackage

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle MIPS main control FSM driving datapath enables and mux selects
module mc_main_fsm
   import mips_ctrl_pkg::*;
#(
   parameter bit SUPPORT_ADDI = 1'b1,
   parameter bit SUPPORT_J    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic [3:0] state,
   output logic       illegal
);
   state_t cur, nxt;
   logic pcwrite, branch, irw, rw, mw, ill;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cur <= S_FETCH;
      else        cur <= nxt;
   always_comb begin
      nxt = S_FETCH;
      pcwrite = 1'b0;
      branch = 1'b0;
      irw = 1'b0;
      rw = 1'b0;
      mw = 1'b0;
      ill = 1'b0;
      iord = 1'b0;
      memtoreg = 1'b0;
      regdst = 1'b0;
      alusrca = 1'b0;
      alusrcb = 2'b00;
      pcsrc = 2'b00;
      aluop = ALUOP_ADD;
      case (cur)
         S_FETCH: begin
            alusrcb = 2'b01;
            irw = 1'b1;
            pcwrite = 1'b1;
            nxt = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI: begin
                  nxt = SUPPORT_ADDI ? S_ADDIEX : S_FETCH;
                  ill = !SUPPORT_ADDI;
               end
               OP_J: begin
                  nxt = SUPPORT_J ? S_JUMP : S_FETCH;
                  ill = !SUPPORT_J;
               end
               default:      ill = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord = 1'b1;
            nxt = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            rw = 1'b1;
         end
         S_MEMWR: begin
            iord = 1'b1;
            mw = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop = ALUOP_FUNCT;
            nxt = S_ALUWB;
         end
         S_ALUWB: begin
            regdst = 1'b1;
            rw = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop = ALUOP_SUB;
            pcsrc = 2'b01;
            branch = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            nxt = S_ADDIWB;
         end
         S_ADDIWB: rw = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcwrite = 1'b1;
         end
         default: nxt = S_FETCH;
      endcase
   end
   // Enables are gated by reset so nothing is written while reset is held
   assign pcen = reset & (pcwrite | (branch & zero));
   assign irwrite = reset & irw;
   assign regwrite = reset & rw;
   assign memwrite = reset & mw;
   assign illegal = reset & ill;
   assign state = cur;
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: random instruction streams on a full-featured and a reduced FSM, checked against a per-opcode model
module tb_mc_main_fsm;
   typedef int iq_t[$];
   logic clk = 1'b0, reset = 1'b0;
   logic [5:0] op_a = 6'h0, op_b = 6'h0;
   logic zero_a = 1'b0, zero_b = 1'b0;
   logic pcen_a, mw_a, irw_a, rw_a, iord_a, m2r_a, rdst_a, asa_a, ill_a;
   logic pcen_b, mw_b, irw_b, rw_b, iord_b, m2r_b, rdst_b, asa_b, ill_b;
   logic [1:0] asb_a, pcs_a, aop_a, asb_b, pcs_b, aop_b;
   logic [3:0] st_a, st_b;
   logic [18:0] obs_a, obs_b;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   mc_main_fsm dut_a (
      .clk(clk), .reset(reset), .op(op_a), .zero(zero_a), .pcen(pcen_a), .memwrite(mw_a),
      .irwrite(irw_a), .regwrite(rw_a), .iord(iord_a), .memtoreg(m2r_a), .regdst(rdst_a),
      .alusrca(asa_a), .alusrcb(asb_a), .pcsrc(pcs_a), .aluop(aop_a), .state(st_a), .illegal(ill_a)
   );
   mc_main_fsm #(.SUPPORT_ADDI(1'b0), .SUPPORT_J(1'b0)) dut_b (
      .clk(clk), .reset(reset), .op(op_b), .zero(zero_b), .pcen(pcen_b), .memwrite(mw_b),
      .irwrite(irw_b), .regwrite(rw_b), .iord(iord_b), .memtoreg(m2r_b), .regdst(rdst_b),
      .alusrca(asa_b), .alusrcb(asb_b), .pcsrc(pcs_b), .aluop(aop_b), .state(st_b), .illegal(ill_b)
   );
   assign obs_a = {st_a, pcen_a, mw_a, irw_a, rw_a, iord_a, m2r_a, rdst_a, asa_a, asb_a, pcs_a, aop_a, ill_a};
   assign obs_b = {st_b, pcen_b, mw_b, irw_b, rw_b, iord_b, m2r_b, rdst_b, asa_b, asb_b, pcs_b, aop_b, ill_b};
   task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %05h want %05h", tag, got, want);
      end
   endtask
   // States visited by one instruction, straight from the per-opcode cycle counts
   function automatic iq_t seq_of(input logic [5:0] op, input bit addi_ok, input bit j_ok);
      case (op)
         6'b100011: return '{0, 1, 2, 3, 4};
         6'b101011: return '{0, 1, 2, 5};
         6'b000000: return '{0, 1, 6, 7};
         6'b000100: return '{0, 1, 8};
         6'b001000: return addi_ok ? '{0, 1, 9, 10} : '{0, 1};
         6'b000010: return j_ok ? '{0, 1, 11} : '{0, 1};
         default:   return '{0, 1};
      endcase
   endfunction
   function automatic logic [18:0] exp_vec(input int s, input logic z, input logic bad, input logic rl);
      logic pcw = 0, br = 0, mw = 0, irw = 0, rw = 0, iord = 0, m2r = 0, rdst = 0, asa = 0, ill = 0, pcen;
      logic [1:0] asb = 0, pcs = 0, aop = 0;
      case (s)
         0:  begin asb = 1; irw = 1; pcw = 1; end
         1:  begin asb = 3; ill = bad; end
         2:  begin asa = 1; asb = 2; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin asa = 1; aop = 2; end
         7:  begin rdst = 1; rw = 1; end
         8:  begin asa = 1; aop = 1; pcs = 1; br = 1; end
         9:  begin asa = 1; asb = 2; end
         10: rw = 1;
         11: begin pcs = 2; pcw = 1; end
         default: ;
      endcase
      pcen = pcw | (br & z);
      if (rl) {pcen, irw, rw, mw, ill} = 5'b0;
      return {s[3:0], pcen, mw, irw, rw, iord, m2r, rdst, asa, asb, pcs, aop, ill};
   endfunction
   task automatic run(input int d, input int n);
      logic [5:0] op;
      logic [5:0] legal[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      iq_t q;
      bit bad;
      for (int i = 0; i < n; i++) begin
         int cat = (i < 8) ? i % 7 : int'($urandom_range(0, 6));
         if (i == 6) op = 6'h3f;
         else if (cat < 6) op = legal[cat];
         else begin
            op = 6'($urandom_range(0, 63));
            while (op inside {legal}) op = 6'($urandom_range(0, 63));
         end
         q = seq_of(op, d == 0, d == 0);
         bad = q.size() == 2;
         if (d == 0) op_a = op; else op_b = op;
         for (int k = 0; k < q.size(); k++) begin
            logic z = 1'($urandom);
            if (d == 0) zero_a = z; else zero_b = z;
            #1;
            check($sformatf("d%0d op%02h step%0d", d, op, k), d == 0 ? obs_a : obs_b, exp_vec(q[k], z, bad, 1'b0));
            @(negedge clk);
         end
      end
   endtask
   initial begin
      op_a = 6'b100011;
      op_b = 6'b100011;
      repeat (2) @(negedge clk);
      check("reset_a", obs_a, exp_vec(0, 1'b0, 1'b0, 1'b1));
      check("reset_b", obs_b, exp_vec(0, 1'b0, 1'b0, 1'b1));
      reset = 1'b1;
      #1 check("release_a", obs_a, exp_vec(0, 1'b0, 1'b0, 1'b0));
      repeat (3) @(negedge clk);
      #1 check("lw_s3_a", obs_a, exp_vec(3, 1'b0, 1'b0, 1'b0));
      #1 reset = 1'b0;
      #1 check("midreset_a", obs_a, exp_vec(0, 1'b0, 1'b0, 1'b1));
      check("midreset_b", obs_b, exp_vec(0, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      check("held_a", obs_a, exp_vec(0, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      reset = 1'b1;
      fork
         run(0, 60);
         run(1, 60);
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
